// File: rtl/manchester_frame_rx.sv
// rtl/manchester_frame_rx.sv - SWIPT2 downlink Manchester frame receiver (optional answer pulses: RX_ANSWER_EN)
module manchester_frame_rx #(
    parameter int HALF_BIT_CYCLES = 100000,
    parameter int THRESH_DIV      = 20
`ifdef RX_ANSWER_EN
    ,
    parameter int ANS_PULSE_CYCLES = 50000,
    parameter int ANS_GAP_CYCLES   = 50000
`endif
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx_en,
    input  logic [11:0] ADC,
    input  logic [11:0] mean_ref,
    output logic        busy,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [1:0]  setting,
    output logic [1:0]  ftype,
    output logic [7:0]  data
`ifdef RX_ANSWER_EN
    ,
    input  logic [1:0]  ans_count,
    output logic        ans_out
`endif
);

    localparam int WCW = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(HALF_BIT_CYCLES - 1);

    typedef enum logic [1:0] {S_HUNT, S_FRAME, S_CHECK, S_GUARD} state_t;

    state_t         state, state_n;
    logic [WCW-1:0] wc;
    logic [5:0]     hb;
    logic [10:0]    mag, peak, pk;
    logic [11:0]    mean_l, thr_src;
    logic [12:0]    thr;
    logic [39:0]    halfbits, hbits_new;
    logic           hit, last_cyc, hb_val;
    logic [18:0]    dec;
    logic           man_err, se_err, cs_err;
    logic [17:0]    fb;

    // Returns {manchester_error, frame bits 19..2}; a 10 pair is 0, 01 is 1.
    function automatic logic [18:0] decode(input logic [39:0] h);
        logic        err;
        logic [17:0] b;
        err = 1'b0;
        b   = '0;
        for (int k = 0; k < 20; k++) err = err | (h[39-2*k] == h[38-2*k]);
        for (int k = 0; k < 18; k++) b[17-k] = h[38-2*k];
        return {err, b};
    endfunction

    always_comb begin
        // Folding around midscale reduces to the low 11 bits, inverted below midscale.
        mag       = ADC[11] ? ADC[10:0] : ~ADC[10:0];
        thr_src   = (state == S_HUNT) ? mean_ref : mean_l;
        thr       = {1'b0, thr_src} + {1'b0, thr_src / 12'(THRESH_DIV)};
        hit       = {2'b00, mag} > thr;
        pk        = (mag > peak) ? mag : peak;
        hb_val    = {2'b00, pk} > thr;
        last_cyc  = (wc == WC_LAST);
        hbits_new = halfbits;
        hbits_new[6'd39 - hb] = hb_val;
        dec       = decode(hbits_new);
        man_err   = dec[18];
        fb        = dec[17:0];
        se_err    = (|fb[17:15]) | (|fb[1:0]);
        cs_err    = fb[2] != (^fb[14:3]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_HUNT;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = (state == S_FRAME);
        if (!rx_en) begin
            state_n = S_HUNT;
        end else begin
            case (state)
                S_HUNT:  if (hit) state_n = S_FRAME;
                S_FRAME: if (last_cyc && hb == 6'd39) state_n = S_CHECK;
                S_CHECK: state_n = S_GUARD;
                S_GUARD: if (last_cyc) state_n = S_HUNT;
                default: state_n = S_HUNT;
            endcase
        end
    end

    // Frame verdict is registered on the last cycle of window 39 so the pulse lands in CHECK.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wc          <= '0;
            hb          <= '0;
            peak        <= '0;
            mean_l      <= '0;
            halfbits    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            setting     <= 2'b00;
            ftype       <= 2'b00;
            data        <= 8'h00;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (!rx_en) begin
                wc   <= '0;
                hb   <= '0;
                peak <= '0;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (hit) begin
                            mean_l <= mean_ref;
                            hb     <= '0;
                            peak   <= mag;
                            wc     <= WCW'(1);
                        end
                    end
                    S_FRAME: begin
                        if (last_cyc) begin
                            halfbits <= hbits_new;
                            peak     <= '0;
                            wc       <= '0;
                            hb       <= hb + 6'd1;
                            if (hb == 6'd39) begin
                                if (man_err) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b01;
                                end else if (se_err) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b10;
                                end else if (cs_err) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b11;
                                end else begin
                                    frame_valid <= 1'b1;
                                    err_code    <= 2'b00;
                                    setting     <= fb[14:13];
                                    ftype       <= fb[12:11];
                                    data        <= fb[10:3];
                                end
                            end
                        end else begin
                            peak <= pk;
                            wc   <= wc + 1'b1;
                        end
                    end
                    S_CHECK: wc <= '0;
                    S_GUARD: wc <= last_cyc ? '0 : wc + 1'b1;
                    default: wc <= '0;
                endcase
            end
        end
    end

`ifdef RX_ANSWER_EN
    localparam int ANS_MAX = (ANS_PULSE_CYCLES > ANS_GAP_CYCLES) ? ANS_PULSE_CYCLES : ANS_GAP_CYCLES;
    localparam int ACW     = (ANS_MAX > 2) ? $clog2(ANS_MAX) : 1;
    localparam logic [ACW-1:0] PULSE_LAST = ACW'(ANS_PULSE_CYCLES - 1);
    localparam logic [ACW-1:0] GAP_LAST   = ACW'(ANS_GAP_CYCLES - 1);

    logic           ans_active;
    logic [1:0]     ans_left;
    logic [ACW-1:0] ans_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ans_active <= 1'b0;
            ans_left   <= 2'd0;
            ans_cnt    <= '0;
            ans_out    <= 1'b0;
        end else if (!ans_active) begin
            if (frame_valid && ans_count != 2'd0) begin
                ans_active <= 1'b1;
                ans_out    <= 1'b1;
                ans_left   <= ans_count;
                ans_cnt    <= '0;
            end
        end else if (ans_out) begin
            if (ans_cnt == PULSE_LAST) begin
                ans_out  <= 1'b0;
                ans_cnt  <= '0;
                ans_left <= ans_left - 2'd1;
                if (ans_left == 2'd1) ans_active <= 1'b0;
            end else begin
                ans_cnt <= ans_cnt + 1'b1;
            end
        end else begin
            if (ans_cnt == GAP_LAST) begin
                ans_out <= 1'b1;
                ans_cnt <= '0;
            end else begin
                ans_cnt <= ans_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_manchester_frame_rx.sv
// tb/tb_manchester_frame_rx.sv - directed table-driven bench for manchester_frame_rx
module tb_manchester_frame_rx;
    localparam int HBC = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx_en = 1'b0;
    logic [11:0] ADC = 12'h70F;
    logic [11:0] mean_ref = 12'h100;
    logic        busy, frame_valid, frame_err;
    logic [1:0]  err_code, setting, ftype;
    logic [7:0]  data;
`ifdef RX_ANSWER_EN
    logic [1:0]  ans_count = 2'd0;
    logic        ans_out;
`endif

    manchester_frame_rx #(
        .HALF_BIT_CYCLES(HBC),
        .THRESH_DIV(20)
`ifdef RX_ANSWER_EN
        ,
        .ANS_PULSE_CYCLES(8),
        .ANS_GAP_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .rx_en(rx_en),
        .ADC(ADC),
        .mean_ref(mean_ref),
        .busy(busy),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .err_code(err_code),
        .setting(setting),
        .ftype(ftype),
        .data(data)
`ifdef RX_ANSWER_EN
        ,
        .ans_count(ans_count),
        .ans_out(ans_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int ecnt = 0;

    always @(negedge clk) begin
        if (frame_valid) vcnt++;
        if (frame_err) ecnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] adc_of(input logic [10:0] m, input logic neg);
        return neg ? (12'h7FF - {1'b0, m}) : (12'h800 + {1'b0, m});
    endfunction

    function automatic logic [19:0] mkbits(input logic [1:0] s, input logic [1:0] t, input logic [7:0] d,
                                           input logic cs_flip, input logic [2:0] st, input logic [1:0] en);
        logic cs;
        cs = (^{s, t, d}) ^ cs_flip;
        return {st, s, t, d, cs, en, 2'b00};
    endfunction

    function automatic logic [39:0] enc(input logic [19:0] b);
        logic [39:0] h;
        for (int k = 0; k < 20; k++) begin
            h[39-2*k] = ~b[19-k];
            h[38-2*k] = b[19-k];
        end
        return h;
    endfunction

    typedef struct {
        logic [39:0] hbits;
        int          weak_idx;
        logic [10:0] weak_mag;
        logic        narrow;
        logic [11:0] mean_mid;
        logic        exp_valid;
        logic [1:0]  exp_code;
        logic [1:0]  exp_set;
        logic [1:0]  exp_ft;
        logic [7:0]  exp_data;
    } vec_t;

    function automatic vec_t mkvec(input logic [39:0] h, input int wi, input logic [10:0] wm, input logic nw,
                                   input logic [11:0] mm, input logic ev, input logic [1:0] ec,
                                   input logic [1:0] es, input logic [1:0] ef, input logic [7:0] ed);
        vec_t v;
        v.hbits = h; v.weak_idx = wi; v.weak_mag = wm; v.narrow = nw; v.mean_mid = mm;
        v.exp_valid = ev; v.exp_code = ec; v.exp_set = es; v.exp_ft = ef; v.exp_data = ed;
        return v;
    endfunction

    // Drives nwin half-bit windows; window 0 cycle 0 is the cycle that triggers frame alignment.
    task automatic send(input logic [39:0] h, input int weak_idx, input logic [10:0] weak_mag,
                        input logic narrow, input logic [11:0] mean_mid, input int nwin);
        logic [10:0] m;
        for (int i = 0; i < nwin; i++) begin
            for (int c = 0; c < HBC; c++) begin
                if (h[39-i]) m = (narrow && i > 0 && c != 3) ? 11'h0F0 : 11'h200;
                else m = 11'h0F0;
                if (i == weak_idx) m = weak_mag;
                ADC = adc_of(m, ((i + c) % 2) == 1);
                @(posedge clk); #1;
                if (i == 0 && c == 0) mean_ref = mean_mid;
            end
        end
        ADC = 12'h70F;
        mean_ref = 12'h100;
    endtask

    vec_t        vecs[12];
    logic [39:0] h;
    int          vb, eb;

    initial begin
        h = enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b0, 3'b000, 2'b00));
        vecs[0] = mkvec(h, -1, 11'h0, 1'b0, 12'h100, 1'b1, 2'b00, 2'b01, 2'b10, 8'hC9);
        h[11] = 1'b1; h[10] = 1'b1;
        vecs[1] = mkvec(h, -1, 11'h0, 1'b0, 12'h100, 1'b0, 2'b01, 2'b01, 2'b10, 8'hC9);
        vecs[2] = mkvec(enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b0, 3'b001, 2'b00)), -1, 11'h0, 1'b0, 12'h100,
                        1'b0, 2'b10, 2'b01, 2'b10, 8'hC9);
        vecs[3] = mkvec(enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b1, 3'b000, 2'b00)), -1, 11'h0, 1'b0, 12'h100,
                        1'b0, 2'b11, 2'b01, 2'b10, 8'hC9);
        vecs[4] = mkvec(enc(mkbits(2'b10, 2'b01, 8'h5B, 1'b0, 3'b000, 2'b00)), -1, 11'h0, 1'b1, 12'h100,
                        1'b1, 2'b00, 2'b10, 2'b01, 8'h5B);
        vecs[5] = mkvec(enc(mkbits(2'b11, 2'b11, 8'hFF, 1'b0, 3'b000, 2'b01)), -1, 11'h0, 1'b0, 12'h100,
                        1'b0, 2'b10, 2'b10, 2'b01, 8'h5B);
        h = enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b0, 3'b001, 2'b00));
        h[17] = 1'b0; h[16] = 1'b0;
        vecs[6] = mkvec(h, -1, 11'h0, 1'b0, 12'h100, 1'b0, 2'b01, 2'b10, 2'b01, 8'h5B);
        vecs[7] = mkvec(enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b1, 3'b000, 2'b10)), -1, 11'h0, 1'b0, 12'h100,
                        1'b0, 2'b10, 2'b10, 2'b01, 8'h5B);
        h = enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b0, 3'b000, 2'b00));
        vecs[8]  = mkvec(h, 28, 11'h10C, 1'b0, 12'h100, 1'b1, 2'b00, 2'b01, 2'b10, 8'hC9);
        vecs[9]  = mkvec(h, 28, 11'h10D, 1'b0, 12'h100, 1'b0, 2'b01, 2'b01, 2'b10, 8'hC9);
        vecs[10] = mkvec(h, 29, 11'h10C, 1'b0, 12'h100, 1'b0, 2'b01, 2'b01, 2'b10, 8'hC9);
        vecs[11] = mkvec(enc(mkbits(2'b00, 2'b00, 8'h00, 1'b0, 3'b000, 2'b00)), -1, 11'h0, 1'b0, 12'h300,
                         1'b1, 2'b00, 2'b00, 2'b00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_fields", {err_code, setting, ftype, data}, 0);
`ifdef RX_ANSWER_EN
        check("rst_ans", ans_out, 0);
`endif
        nrst = 1'b1;
        rx_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        for (int n = 0; n < 12; n++) begin
            vb = vcnt;
            eb = ecnt;
            send(vecs[n].hbits, vecs[n].weak_idx, vecs[n].weak_mag, vecs[n].narrow, vecs[n].mean_mid, 40);
            check($sformatf("v%0d_valid", n), frame_valid, vecs[n].exp_valid);
            check($sformatf("v%0d_err", n), frame_err, !vecs[n].exp_valid);
            check($sformatf("v%0d_fields", n), {setting, ftype, data},
                  {vecs[n].exp_set, vecs[n].exp_ft, vecs[n].exp_data});
            if (!vecs[n].exp_valid) check($sformatf("v%0d_code", n), err_code, vecs[n].exp_code);
            @(posedge clk); #1;
            check($sformatf("v%0d_pulse_end", n), {frame_valid, frame_err}, 0);
            check($sformatf("v%0d_vcount", n), vcnt - vb, vecs[n].exp_valid);
            check($sformatf("v%0d_ecount", n), ecnt - eb, !vecs[n].exp_valid);
            repeat (12) @(posedge clk);
            #1;
        end

        // rx_en dropped at hb=20, then a valid frame
        vb = vcnt;
        eb = ecnt;
        send(enc(mkbits(2'b10, 2'b10, 8'h77, 1'b0, 3'b000, 2'b00)), -1, 11'h0, 1'b0, 12'h100, 20);
        check("abort_busy_mid", busy, 1);
        rx_en = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_off", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rx_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_pulse", {vcnt - vb, ecnt - eb}, 0);
        check("abort_fields", {setting, ftype, data}, {2'b00, 2'b00, 8'h00});
`ifdef RX_ANSWER_EN
        ans_count = 2'd2;
`endif
        send(enc(mkbits(2'b11, 2'b00, 8'h81, 1'b0, 3'b000, 2'b00)), -1, 11'h0, 1'b0, 12'h100, 40);
        check("after_abort_valid", frame_valid, 1);
        check("after_abort_fields", {setting, ftype, data}, {2'b11, 2'b00, 8'h81});
`ifdef RX_ANSWER_EN
        for (int j = 1; j <= 26; j++) begin
            @(posedge clk); #1;
            check($sformatf("ans_%0d", j), ans_out, (j <= 8) || (j >= 17 && j <= 24));
        end
        ans_count = 2'd0;
`endif
        repeat (12) @(posedge clk);
        #1;

        // asynchronous reset mid-frame
        vb = vcnt;
        eb = ecnt;
        send(enc(mkbits(2'b01, 2'b10, 8'hC9, 1'b0, 3'b000, 2'b00)), -1, 11'h0, 1'b0, 12'h100, 10);
        check("nrst_busy_mid", busy, 1);
        nrst = 1'b0;
        #1;
        check("nrst_busy", busy, 0);
        check("nrst_fields", {err_code, setting, ftype, data}, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("nrst_no_pulse", {vcnt - vb, ecnt - eb}, 0);
        check("nrst_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
